lfsr_gen: RTL and testbench
===========================

// Module: lfsr_gen
// PURPOSE
//  Parametrised LFSR pseudo-random generator: Fibonacci or Galois form, any width and tap set, STEP bits per clock.
//  Supports seed load, enable, all-zero lock-up recovery and sequence-period measurement.
//  Feeds test-pattern generators, scramblers and BIST logic.
//  Replaces fixed-width, fixed-tap shift registers in new designs.
// PARAMETERS
//  WIDTH  8      state width, 2..32
//  TAPS   8'h23  tap mask; bit i set = state[i] in feedback; TAPS[0] must be 1 (Fib), TAPS[WIDTH-1] must be 1 (Gal)
//  INIT   1      reset/recovery state; must be nonzero
//  MODE   0      0 = Fibonacci (LFSR_FIB), 1 = Galois (LFSR_GAL)
//  STEP   1      single steps per enabled clock, 1..WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active-high
//  en           in   1      advance STEP steps this cycle
//  load         in   1      load seed this cycle
//  seed         in   WIDTH  seed value
//  result       out  WIDTH  current state
//  out_bits     out  STEP   serial bits produced last advance; out_bits[0] oldest
//  valid        out  1      1 for the cycle after an advance, else 0
//  lockup       out  1      1-cycle pulse: all-zero state/seed replaced by INIT
//  period_done  out  1      1-cycle pulse: state returned to reference state
//  period       out  WIDTH  enabled cycles of last full period; saturates at all-ones
// BEHAVIOUR
//  Single step, Fibonacci: fb = ^(s & TAPS); s' = {fb, s[WIDTH-1:1]}; bit out = s[0].
//  Single step, Galois: s' = (s >> 1) ^ ({WIDTH{s[0]}} & TAPS); bit out = s[0].
//  Advance = STEP chained single steps in one cycle; out_bits[k] = bit out of k-th step.
//  Priority: rst > load > en. All outputs are registered.
//  rst: result=INIT, ref=INIT, cnt=0, period=0, out_bits=0; valid, lockup, period_done = 0.
//  load: seed!=0: result=seed, ref=seed, cnt=0, period unchanged, valid=0.
//  load with seed==0: result=INIT, ref=INIT, lockup=1 next cycle.
//  en (no load): result advances; valid=1 next cycle.
//  Lock-up: en with result==0 (reachable only via non-primitive TAPS corruption): result=INIT, ref=INIT, cnt=0, lockup=1, valid=0.
//  Period counter cnt (WIDTH bits) increments per advance; saturates at all-ones.
//  If the advanced state == ref: period=cnt+1 (saturating), cnt=0, period_done=1 the same edge.
//  en=0: state, cnt, out_bits hold; valid=0.
//  rst or load mid-sequence discards cnt; no period_done is issued for the aborted run.
//  Latency: result reflects load/advance one clock after the sampling edge; no combinational input-to-output path.
// STRUCTURE
//  Package lfsr_pkg:
//   - LFSR_FIB=0, LFSR_GAL=1.
//   - Maximal-length tap constants LFSR_TAPS_4=4'h3, LFSR_TAPS_8, LFSR_TAPS_16.
//   - Function lfsr_next(state, taps, mode) returning the single-step state.
//  Sub-module lfsr_step: combinational single step (state in, state out, bit out).
//   - Instantiated STEP times in a generate chain.
//  Top holds state, ref, cnt and period registers plus the control priority logic.
// TESTING
//  T1 W=8 TAPS=8'h23 FIB STEP=1: rst, then en x2 -> result 8'h01 -> 8'h80 -> 8'h40; out_bits 1, then 0.
//  T2 W=4 TAPS=4'h3 FIB: en held from INIT=1 -> period_done on 15th advance; period=15; 15 distinct nonzero states.
//  T3 W=4 TAPS=4'hC GAL: from 1, en -> 4'hC, 4'h6, 4'h3, 4'hD; period=15 after full run.
//  T4 load seed=0 -> result=INIT, lockup=1 for exactly one cycle, valid=0.
//     load seed=4'h9 with en=1 -> result=4'h9 (load wins).
//  T5 W=8 STEP=8: one advance equals 8 single steps of a STEP=1 reference model; out_bits = old result.
//  T6 rst during a run (cnt=7) -> all outputs at reset values next cycle.
//     No period_done until a fresh full period; en=0 for 5 cycles holds result and cnt.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: feedback form selector, maximal-length
// tap masks and a single-step helper usable by any width up to 32.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  // Primitive polynomials: x^4+x+1, x^8+x^4+x^3+x^2+1,
  // x^16+x^5+x^3+x^2+1 (the x^W term is implicit).
  localparam logic [3:0]  LFSR_TAPS_4  = 4'h3;
  localparam logic [7:0]  LFSR_TAPS_8  = 8'h1D;
  localparam logic [15:0] LFSR_TAPS_16 = 16'h002D;

  // One shift of a width-bit LFSR held in the low bits of state.
  function automatic logic [31:0] lfsr_next(
    input logic [31:0] state,
    input logic [31:0] taps,
    input lfsr_mode_e  mode,
    input int unsigned width
  );
    logic [31:0] ns;
    logic        fb;
    fb = ^(state & taps);
    if (mode == LFSR_GAL)
      ns = (state >> 1) ^ ({32{state[0]}} & taps);
    else
      ns = (state >> 1) | ({31'b0, fb} << (width - 1));
    return ns;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single LFSR step.
// Ports: i_state (current), o_state (next), o_bit (bit shifted out).
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(8'h23),
  parameter lfsr_mode_e        MODE  = LFSR_FIB
)(
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_state,
  output logic             o_bit
);

  assign o_bit = i_state[0];

  generate
    if (MODE == LFSR_GAL) begin : g_gal
      assign o_state = (i_state >> 1)
                     ^ ({WIDTH{i_state[0]}} & TAPS);
    end else begin : g_fib
      logic w_fb;
      assign w_fb    = ^(i_state & TAPS);
      assign o_state = {w_fb, i_state[WIDTH-1:1]};
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator: STEP shifts per enabled clock, seed load,
// all-zero recovery and period measurement against a reference state.
// Ports: clk, rst (sync, high), en, load, seed -> result, out_bits,
//        valid, lockup, period_done, period (all registered).
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h23),
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1),
  parameter lfsr_mode_e       MODE  = LFSR_FIB,
  parameter int unsigned      STEP  = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] result,
  output logic [STEP-1:0]  out_bits,
  output logic             valid,
  output logic             lockup,
  output logic             period_done,
  output logic [WIDTH-1:0] period
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic [STEP-1:0]  r_bits;
  logic             r_valid;
  logic             r_lockup;
  logic             r_done;

  logic [WIDTH-1:0] w_chain [STEP+1];
  logic [STEP-1:0]  w_bits;
  logic [WIDTH-1:0] w_adv;
  logic [WIDTH-1:0] w_cnt_inc;

  assign w_chain[0] = r_state;

  generate
    for (genvar k = 0; k < STEP; k++) begin : g_step
      lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
      ) u_step (
        .i_state (w_chain[k]),
        .o_state (w_chain[k+1]),
        .o_bit   (w_bits[k])
      );
    end
  endgenerate

  assign w_adv     = w_chain[STEP];
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= INIT;
      r_ref    <= INIT;
      r_cnt    <= '0;
      r_period <= '0;
      r_bits   <= '0;
      r_valid  <= 1'b0;
      r_lockup <= 1'b0;
      r_done   <= 1'b0;
    end else if (load) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (seed == '0) begin
        r_state  <= INIT;
        r_ref    <= INIT;
        r_lockup <= 1'b1;
      end else begin
        r_state  <= seed;
        r_ref    <= seed;
        r_lockup <= 1'b0;
      end
    end else if (en) begin
      if (r_state == '0) begin
        // Only reachable with a corrupted/non-primitive tap set.
        r_state  <= INIT;
        r_ref    <= INIT;
        r_cnt    <= '0;
        r_valid  <= 1'b0;
        r_lockup <= 1'b1;
        r_done   <= 1'b0;
      end else begin
        r_state  <= w_adv;
        r_bits   <= w_bits;
        r_valid  <= 1'b1;
        r_lockup <= 1'b0;
        if (w_adv == r_ref) begin
          r_period <= w_cnt_inc;
          r_cnt    <= '0;
          r_done   <= 1'b1;
        end else begin
          r_cnt  <= w_cnt_inc;
          r_done <= 1'b0;
        end
      end
    end else begin
      r_valid  <= 1'b0;
      r_lockup <= 1'b0;
      r_done   <= 1'b0;
    end
  end

  assign result      = r_state;
  assign out_bits    = r_bits;
  assign valid       = r_valid;
  assign lockup      = r_lockup;
  assign period_done = r_done;
  assign period      = r_period;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: four configurations driven
// by directed and random stimulus against a behavioural model.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       en1, ld1, v1, lk1, pd1;
  logic [7:0] sd1, r1, p1;
  logic [0:0] ob1;

  logic       en2, ld2, v2, lk2, pd2;
  logic [3:0] sd2, r2, p2;
  logic [0:0] ob2;

  logic       en3, ld3, v3, lk3, pd3;
  logic [3:0] sd3, r3, p3;
  logic [0:0] ob3;

  logic       en5, ld5, v5, lk5, pd5;
  logic [7:0] sd5, r5, p5, ob5;

  int checks = 0;
  int errors = 0;

  lfsr_gen #(.WIDTH(8), .TAPS(8'h23), .INIT(8'h01),
             .MODE(LFSR_FIB), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .en(en1), .load(ld1), .seed(sd1),
    .result(r1), .out_bits(ob1), .valid(v1), .lockup(lk1),
    .period_done(pd1), .period(p1));

  lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .INIT(4'h1),
             .MODE(LFSR_FIB), .STEP(1)) u2 (
    .clk(clk), .rst(rst), .en(en2), .load(ld2), .seed(sd2),
    .result(r2), .out_bits(ob2), .valid(v2), .lockup(lk2),
    .period_done(pd2), .period(p2));

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .INIT(4'h1),
             .MODE(LFSR_GAL), .STEP(1)) u3 (
    .clk(clk), .rst(rst), .en(en3), .load(ld3), .seed(sd3),
    .result(r3), .out_bits(ob3), .valid(v3), .lockup(lk3),
    .period_done(pd3), .period(p3));

  lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .INIT(8'h01),
             .MODE(LFSR_FIB), .STEP(8)) u5 (
    .clk(clk), .rst(rst), .en(en5), .load(ld5), .seed(sd5),
    .result(r5), .out_bits(ob5), .valid(v5), .lockup(lk5),
    .period_done(pd5), .period(p5));

  // Reference: Fibonacci appends the tap parity at the top while the
  // register halves; Galois halves and folds the taps in on a 1 out.
  function automatic int unsigned m_next(input int unsigned s,
                                         input int unsigned taps,
                                         input bit gal,
                                         input int w);
    int p;
    if (gal)
      return (s % 2 == 1) ? ((s / 2) ^ taps) : (s / 2);
    p = 0;
    for (int i = 0; i < w; i++)
      if (((s >> i) & 1) == 1 && ((taps >> i) & 1) == 1)
        p = 1 - p;
    return s / 2 + p * (1 << (w - 1));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    en1 = 0; ld1 = 0; sd1 = '0;
    en2 = 0; ld2 = 0; sd2 = '0;
    en3 = 0; ld3 = 0; sd3 = '0;
    en5 = 0; ld5 = 0; sd5 = '0;
  endtask

  task automatic test_reset;
    idle_all();
    rst = 1;
    tick();
    tick();
    checks++;
    if ({r1, v1, lk1, pd1, p1, ob1} !== {8'h01, 3'b000, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_u1 got %h exp %h",
               {r1, v1, lk1, pd1, p1, ob1}, {8'h01, 3'b000, 8'h00, 1'b0});
    end
    checks++;
    if ({r2, v2, lk2, pd2, p2, ob2} !== {4'h1, 3'b000, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_u2 got %h", {r2, v2, lk2, pd2, p2, ob2});
    end
    checks++;
    if ({r3, v3, lk3, pd3, p3, ob3} !== {4'h1, 3'b000, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_u3 got %h", {r3, v3, lk3, pd3, p3, ob3});
    end
    checks++;
    if ({r5, v5, lk5, pd5, p5, ob5} !== {8'h01, 3'b000, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_u5 got %h", {r5, v5, lk5, pd5, p5, ob5});
    end
    rst = 0;
  endtask

  task automatic test_fib_basic;
    en1 = 1;
    tick();
    checks++;
    if ({r1, ob1, v1} !== {8'h80, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL fib_step1 got r=%h b=%b v=%b exp r=80 b=1 v=1",
               r1, ob1, v1);
    end
    tick();
    checks++;
    if ({r1, ob1, v1} !== {8'h40, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL fib_step2 got r=%h b=%b v=%b exp r=40 b=0 v=1",
               r1, ob1, v1);
    end
    en1 = 0;
    tick();
    checks++;
    if ({r1, ob1, v1} !== {8'h40, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fib_hold got r=%h b=%b v=%b exp r=40 b=0 v=0",
               r1, ob1, v1);
    end
  endtask

  task automatic test_fib_period;
    int unsigned s;
    logic [15:0] seen;
    bit          found;
    s = 1;
    seen = '0;
    found = 0;
    en2 = 1;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      s = m_next(s, 4'h3, 0, 4);
      seen[s] = 1'b1;
      checks++;
      if (r2 !== 4'(s) || pd2 !== (s == 1)) begin
        errors++;
        $display("FAIL fib4_adv%0d got r=%h pd=%b exp r=%h pd=%b",
                 i, r2, pd2, s[3:0], (s == 1));
      end
      if (s == 1) begin
        found = 1;
        checks++;
        if (p2 !== 4'd15 || i != 15) begin
          errors++;
          $display("FAIL fib4_period got %0d at adv %0d exp 15", p2, i);
        end
      end
    end
    en2 = 0;
    checks++;
    if (!found || $countones(seen) != 15 || seen[0]) begin
      errors++;
      $display("FAIL fib4_distinct got %0d states exp 15",
               $countones(seen));
    end
    tick();
  endtask

  task automatic test_gal_seq;
    logic [3:0] tbl [4];
    int unsigned s;
    tbl = '{4'hC, 4'h6, 4'h3, 4'hD};
    s = 1;
    en3 = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      s = m_next(s, 4'hC, 1, 4);
      checks++;
      if (r3 !== 4'(s) || (i <= 4 && r3 !== tbl[i-1]) ||
          pd3 !== (i == 15)) begin
        errors++;
        $display("FAIL gal_adv%0d got r=%h pd=%b exp r=%h", i, r3, pd3,
                 s[3:0]);
      end
    end
    checks++;
    if (p3 !== 4'd15) begin
      errors++;
      $display("FAIL gal_period got %0d exp 15", p3);
    end
    en3 = 0;
    tick();
  endtask

  task automatic test_load_lockup;
    en2 = 1;
    tick();
    tick();
    en2 = 0;
    ld2 = 1;
    sd2 = 4'h0;
    tick();
    checks++;
    if ({r2, lk2, v2, pd2} !== {4'h1, 1'b1, 1'b0, 1'b0} || p2 !== 4'd15) begin
      errors++;
      $display("FAIL load_zero got r=%h lk=%b v=%b p=%0d exp r=1 lk=1 v=0",
               r2, lk2, v2, p2);
    end
    ld2 = 0;
    tick();
    checks++;
    if ({r2, lk2} !== {4'h1, 1'b0}) begin
      errors++;
      $display("FAIL lockup_pulse got r=%h lk=%b exp r=1 lk=0", r2, lk2);
    end
    ld2 = 1;
    sd2 = 4'h9;
    en2 = 1;
    tick();
    checks++;
    if ({r2, lk2, v2} !== {4'h9, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_wins got r=%h lk=%b v=%b exp r=9", r2, lk2, v2);
    end
    ld2 = 0;
    en2 = 0;
    tick();
  endtask

  task automatic test_step8;
    int unsigned s;
    logic [7:0]  old;
    logic [7:0]  eb;
    s = $urandom_range(1, 255);
    ld5 = 1;
    sd5 = 8'(s);
    tick();
    ld5 = 0;
    en5 = 1;
    for (int n = 0; n < 10; n++) begin
      old = 8'(s);
      for (int k = 0; k < 8; k++) begin
        eb[k] = s[0];
        s = m_next(s, 8'h1D, 0, 8);
      end
      tick();
      checks++;
      if (r5 !== 8'(s) || ob5 !== eb || ob5 !== old || v5 !== 1'b1) begin
        errors++;
        $display("FAIL step8_adv%0d got r=%h b=%h exp r=%h b=%h",
                 n, r5, ob5, s[7:0], old);
      end
      if ($urandom_range(0, 2) == 0) begin
        en5 = 0;
        ld5 = 1;
        s = $urandom_range(1, 255);
        sd5 = 8'(s);
        tick();
        ld5 = 0;
        en5 = 1;
      end
    end
    en5 = 0;
    tick();
  endtask

  task automatic test_abort;
    int unsigned s;
    rst = 1;
    tick();
    rst = 0;
    en2 = 1;
    repeat (7) tick();
    rst = 1;
    tick();
    checks++;
    if ({r2, v2, lk2, pd2, p2, ob2} !== {4'h1, 3'b000, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset got %h", {r2, v2, lk2, pd2, p2, ob2});
    end
    rst = 0;
    s = 1;
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) begin
        en2 = 0;
        for (int j = 0; j < 5; j++) begin
          tick();
          checks++;
          if (r2 !== 4'(s) || v2 !== 1'b0 || pd2 !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold%0d got r=%h v=%b exp r=%h",
                     j, r2, v2, s[3:0]);
          end
        end
        en2 = 1;
      end
      tick();
      s = m_next(s, 4'h3, 0, 4);
      checks++;
      if (r2 !== 4'(s) || pd2 !== (i == 15)) begin
        errors++;
        $display("FAIL fresh_adv%0d got r=%h pd=%b exp r=%h",
                 i, r2, pd2, s[3:0]);
      end
    end
    checks++;
    if (p2 !== 4'd15) begin
      errors++;
      $display("FAIL fresh_period got %0d exp 15", p2);
    end
    en2 = 0;
    tick();
  endtask

  task automatic test_random;
    int unsigned ms, mref, mcnt, mper, c, sd;
    logic        e_lk, e_pd, e_v, e_ob;
    bit          ld, en;
    rst = 1;
    tick();
    rst = 0;
    ms = 1; mref = 1; mcnt = 0; mper = 0; e_ob = 0;
    for (int n = 0; n < 400; n++) begin
      ld = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      sd = $urandom_range(0, 15);
      ld3 = ld;
      en3 = en;
      sd3 = 4'(sd);
      e_lk = 0; e_pd = 0; e_v = 0;
      if (ld) begin
        ms = (sd == 0) ? 1 : sd;
        mref = ms;
        mcnt = 0;
        e_lk = (sd == 0);
      end else if (en) begin
        e_ob = ms[0];
        ms = m_next(ms, 4'hC, 1, 4);
        e_v = 1;
        c = (mcnt >= 15) ? 15 : mcnt + 1;
        if (ms == mref) begin
          mper = c;
          mcnt = 0;
          e_pd = 1;
        end else begin
          mcnt = c;
        end
      end
      tick();
      checks++;
      if ({r3, v3, lk3, pd3, p3, ob3} !==
          {4'(ms), e_v, e_lk, e_pd, 4'(mper), e_ob}) begin
        errors++;
        $display("FAIL rand%0d got r=%h v=%b lk=%b pd=%b p=%0d b=%b exp r=%h v=%b lk=%b pd=%b p=%0d b=%b",
                 n, r3, v3, lk3, pd3, p3, ob3,
                 ms[3:0], e_v, e_lk, e_pd, mper, e_ob);
      end
    end
    idle_all();
    tick();
  endtask

  initial begin
    rst = 1;
    idle_all();
    test_reset();
    test_fib_basic();
    test_fib_period();
    test_gal_seq();
    test_load_lockup();
    test_step8();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
